mem_line_fetch: RTL and testbench

//  Read initiator: fills one cache line from the word-addressed read-only memory port (read_en/addr -> data/dvalid).

---
 rtl/mem_line_fetch_if.sv | 36 +++
 rtl/mem_line_fetch.sv | 122 ++++++++++++
 tb/tb_mem_line_fetch.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_fetch_if.sv
// Bundle between the line-fill unit, its cache controller and the memory read port.
// master is the fill unit; slave is the controller/memory side.
interface mem_line_fetch_if #(
    parameter int LINE_WORDS = 4
);
    localparam int IDX_BITS = $clog2(LINE_WORDS);

    logic                    req_valid;
    logic [31:0]             req_addr;
    logic                    req_ready;
    logic [31:0]             mem_addr;
    logic                    mem_read_en;
    logic [31:0]             mem_data;
    logic                    mem_dvalid;
    logic                    word_valid;
    logic [IDX_BITS-1:0]     word_index;
    logic [31:0]             word_data;
    logic [32*LINE_WORDS-1:0] line_data;
    logic                    line_done;
    logic                    busy;
    logic                    err;

    modport master (
        input  req_valid, req_addr, mem_data, mem_dvalid,
        output req_ready, mem_addr, mem_read_en,
        output word_valid, word_index, word_data,
        output line_data, line_done, busy, err
    );

    modport slave (
        output req_valid, req_addr, mem_data, mem_dvalid,
        input  req_ready, mem_addr, mem_read_en,
        input  word_valid, word_index, word_data,
        input  line_data, line_done, busy, err
    );
endinterface

// File: rtl/mem_line_fetch.sv
// Cache line fill: critical-word-first, wrapping reads of one line from a word memory.
// MEM_FETCH_TIMEOUT_EN adds TIMEOUT_CYCLES and a per-word dvalid watchdog driving err.
module mem_line_fetch #(
    parameter int LINE_WORDS = 4
`ifdef MEM_FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clk,
    input  logic              reset,
    mem_line_fetch_if.master  bus
);
    localparam int IDX_BITS = $clog2(LINE_WORDS);
    localparam int CNT_BITS = IDX_BITS + 1;
    localparam logic [31:0] OFF_MASK = 32'(4 * LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP,
        DONE
    } state_t;

    state_t              state;
    logic [31:0]         line_base;
    logic [IDX_BITS-1:0] idx;
    logic [IDX_BITS-1:0] idx_nxt;
    logic [CNT_BITS-1:0] cnt;
    logic                last_word;

`ifdef MEM_FETCH_TIMEOUT_EN
    localparam int WAIT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_BITS-1:0] wait_cnt;
`endif

    assign idx_nxt   = idx + IDX_BITS'(1);
    assign last_word = (cnt == CNT_BITS'(LINE_WORDS - 1));

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);

    // Fill sequencer: all memory-side and stream outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            line_base       <= '0;
            idx             <= '0;
            cnt             <= '0;
            bus.mem_addr    <= '0;
            bus.mem_read_en <= 1'b0;
            bus.word_valid  <= 1'b0;
            bus.word_index  <= '0;
            bus.word_data   <= '0;
            bus.line_data   <= '0;
            bus.line_done   <= 1'b0;
            bus.err         <= 1'b0;
`ifdef MEM_FETCH_TIMEOUT_EN
            wait_cnt        <= '0;
`endif
        end else begin
            bus.word_valid <= 1'b0;
            bus.line_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        line_base       <= bus.req_addr & ~OFF_MASK;
                        idx             <= IDX_BITS'(bus.req_addr >> 2);
                        cnt             <= '0;
                        bus.err         <= 1'b0;
                        bus.mem_addr    <= bus.req_addr & ~32'h3;
                        bus.mem_read_en <= 1'b1;
                        state           <= REQ;
`ifdef MEM_FETCH_TIMEOUT_EN
                        wait_cnt        <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus.mem_dvalid) begin
                        bus.word_data                <= bus.mem_data;
                        bus.line_data[{idx, 5'd0} +: 32] <= bus.mem_data;
                        bus.word_valid               <= 1'b1;
                        bus.word_index               <= idx;
                        cnt                          <= cnt + CNT_BITS'(1);
                        idx                          <= idx_nxt;
                        bus.mem_addr <= line_base | (32'(idx_nxt) << 2);
                        bus.mem_read_en              <= 1'b0;
                        if (last_word) begin
                            bus.line_done <= 1'b1;
                            state         <= DONE;
                        end else begin
                            state <= GAP;
                        end
                    end
`ifdef MEM_FETCH_TIMEOUT_EN
                    else if (wait_cnt == WAIT_BITS'(TIMEOUT_CYCLES - 1)) begin
                        bus.mem_read_en <= 1'b0;
                        bus.err         <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_BITS'(1);
                    end
`endif
                end
                GAP: begin
                    bus.mem_read_en <= 1'b1;
                    state           <= REQ;
`ifdef MEM_FETCH_TIMEOUT_EN
                    wait_cnt        <= '0;
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_line_fetch.sv
// Directed bench for mem_line_fetch with a latency-programmable word memory stub.
// Memory word i holds 0xA000_0000 + i.
module tb_mem_line_fetch;
    logic clk;
    logic reset;

    mem_line_fetch_if #(.LINE_WORDS(4)) bus ();

`ifdef MEM_FETCH_TIMEOUT_EN
    mem_line_fetch #(.LINE_WORDS(4), .TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`else
    mem_line_fetch #(.LINE_WORDS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int lat    = 1;
    bit mem_on = 1'b1;
    int age    = 0;

    int cyc, n_done, n_gap, n_unstable, n_ren, n_rdy_bad;
    logic        prev_ren;
    logic [31:0] prev_addr;
    logic [1:0]  wq_idx[$];
    logic [31:0] wq_dat[$];
    logic [31:0] aq[$];

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear();
        cyc = 0; n_done = 0; n_gap = 0; n_unstable = 0;
        n_ren = 0; n_rdy_bad = 0;
        wq_idx.delete(); wq_dat.delete(); aq.delete();
    endtask

    // One clock: observe registered outputs, then update the memory stub.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.word_valid) begin
            wq_idx.push_back(bus.word_index);
            wq_dat.push_back(bus.word_data);
        end
        if (bus.line_done) n_done++;
        if (bus.mem_read_en && !prev_ren) aq.push_back(bus.mem_addr);
        if (bus.mem_read_en && prev_ren && bus.mem_addr != prev_addr)
            n_unstable++;
        if (bus.mem_read_en) n_ren++;
        if (bus.busy && !bus.mem_read_en && !bus.line_done) n_gap++;
        if (bus.busy && bus.req_ready) n_rdy_bad++;
        prev_ren  = bus.mem_read_en;
        prev_addr = bus.mem_addr;
        if (bus.mem_read_en && mem_on && age == lat) begin
            bus.mem_dvalid = 1'b1;
            bus.mem_data   = 32'hA000_0000 + (bus.mem_addr >> 2);
        end else begin
            bus.mem_dvalid = 1'b0;
            bus.mem_data   = 32'hDEAD_BEEF;
        end
        age = bus.mem_read_en ? age + 1 : 0;
    endtask

    // Fetch one line and check stream, addresses, timing and final line.
    task automatic run_line(input logic [31:0] addr, input bit hold);
        logic [31:0]  bw;
        int           st;
        logic [127:0] exp_line;
        bw = (addr & ~32'hF) >> 2;
        st = int'((addr >> 2) & 32'h3);
        for (int k = 0; k < 4; k++)
            exp_line[32*k +: 32] = 32'hA000_0000 + bw + 32'(k);
        clear();
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        tick();
        if (!hold) bus.req_valid = 1'b0;
        cyc = 0;
        chk("acc_err", 128'(bus.err), 128'(0));
        chk("acc_ren", 128'(bus.mem_read_en), 128'(1));
        chk("acc_addr", 128'(bus.mem_addr), 128'(addr & ~32'h3));
        for (int i = 0; i < 300 && n_done == 0 && !bus.err; i++) begin
            if (hold) bus.req_addr = 32'h200 + 32'(i) * 4;
            tick();
        end
        bus.req_valid = 1'b0;
        chk("done_cnt", 128'(n_done), 128'(1));
        chk("cycles", 128'(cyc), 128'(4 * (lat + 2) - 1));
        chk("n_words", 128'(wq_idx.size()), 128'(4));
        for (int i = 0; i < wq_idx.size() && i < 4; i++) begin
            chk("w_idx", 128'(wq_idx[i]), 128'((st + i) % 4));
            chk("w_dat", 128'(wq_dat[i]),
                128'(32'hA000_0000 + bw + 32'((st + i) % 4)));
        end
        chk("n_addr", 128'(aq.size()), 128'(4));
        for (int i = 0; i < aq.size() && i < 4; i++)
            chk("m_addr", 128'(aq[i]),
                128'((bw + 32'((st + i) % 4)) << 2));
        chk("line", bus.line_data, exp_line);
        chk("gaps", 128'(n_gap), 128'(3));
        chk("unstable", 128'(n_unstable), 128'(0));
        chk("ren_cyc", 128'(n_ren), 128'(4 * (lat + 1)));
        chk("rdy_busy", 128'(n_rdy_bad), 128'(0));
        tick();
        chk("idle_rdy", 128'(bus.req_ready), 128'(1));
        chk("idle_busy", 128'(bus.busy), 128'(0));
    endtask

    initial begin
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.mem_dvalid = 1'b0;
        bus.mem_data   = '0;
        prev_ren       = 1'b0;
        prev_addr      = '0;
        clear();
        tick();
        tick();
        chk("rst_ren", 128'(bus.mem_read_en), 128'(0));
        chk("rst_rdy", 128'(bus.req_ready), 128'(1));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_err", 128'(bus.err), 128'(0));
        chk("rst_line", bus.line_data, 128'(0));
        chk("rst_done", 128'(bus.line_done), 128'(0));
        reset = 1'b0;
        tick();

        // aligned line, latency 1
        lat = 1;
        run_line(32'h20, 1'b0);
        chk("t1_line", bus.line_data,
            128'hA000000B_A000000A_A0000009_A0000008);

        // unaligned critical-word-first with wrap
        run_line(32'h2B, 1'b0);
        chk("t2_line", bus.line_data,
            128'hA000000B_A000000A_A0000009_A0000008);
        chk("t2_a0", 128'(aq.size() > 0 ? aq[0] : 32'hX), 128'(32'h28));
        chk("t2_a2", 128'(aq.size() > 2 ? aq[2] : 32'hX), 128'(32'h20));

        // latency 5
        lat = 5;
        run_line(32'h34, 1'b0);

        // latency 0: dvalid in the first REQ cycle
        lat = 0;
        run_line(32'h5C, 1'b0);

        // reset during second REQ
        lat = 1;
        clear();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h20;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 50 && aq.size() < 2; i++) tick();
        chk("t4_req2", 128'(aq.size()), 128'(2));
        reset = 1'b1;
        #1;
        chk("t4_ren", 128'(bus.mem_read_en), 128'(0));
        chk("t4_busy", 128'(bus.busy), 128'(0));
        chk("t4_rdy", 128'(bus.req_ready), 128'(1));
        chk("t4_addr", 128'(bus.mem_addr), 128'(0));
        chk("t4_wv", 128'(bus.word_valid), 128'(0));
        chk("t4_wd", 128'(bus.word_data), 128'(0));
        chk("t4_line", bus.line_data, 128'(0));
        tick();
        reset = 1'b0;
        tick();
        run_line(32'h40, 1'b0);
        chk("t4_new", bus.line_data,
            128'hA0000013_A0000012_A0000011_A0000010);

        // req_valid held with changing address while busy
        run_line(32'h60, 1'b1);
        chk("t5_line", bus.line_data,
            128'hA000001B_A000001A_A0000019_A0000018);

`ifdef MEM_FETCH_TIMEOUT_EN
        // watchdog: stub never answers
        mem_on = 1'b0;
        clear();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h80;
        tick();
        bus.req_valid = 1'b0;
        cyc = 0;
        for (int i = 0; i < 50 && !bus.err; i++) tick();
        chk("to_cyc", 128'(cyc), 128'(8));
        chk("to_err", 128'(bus.err), 128'(1));
        chk("to_ren", 128'(bus.mem_read_en), 128'(0));
        chk("to_busy", 128'(bus.busy), 128'(0));
        chk("to_done", 128'(n_done), 128'(0));
        tick();
        chk("to_sticky", 128'(bus.err), 128'(1));
        mem_on = 1'b1;
        run_line(32'hC4, 1'b0);
`else
        chk("err_tied", 128'(bus.err), 128'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
